key_schedule_seq: RTL and testbench
===================================

// Module: key_schedule_seq
// PURPOSE
//  Sequential AES-128 key expansion. Accepts a 128-bit cipher key and emits round keys RK0..RK10, one per
//  valid/ready beat. Sits directly upstream of the round datapath: RK0 and RK1 feed the first round's k0/k1,
//  and RK2..RK10 feed the later rounds. Holds one working key register and computes one expansion step per accepted beat.
// PARAMETERS
//  NR        10   last round index; 10 = AES-128 (fixed, only legal value)
//  KEY_W     128  key/round-key width (fixed)
// PORTS
//  clk         in   1    rising-edge clock
//  rst_n       in   1    asynchronous, active-low reset
//  key_in      in   128  cipher key, byte 0 = key_in[127:120]
//  key_valid   in   1    key_in valid
//  key_ready   out  1    block can accept a new key
//  rk_out      out  128  current round key, same byte order as key_in
//  rk_idx      out  4    round index of rk_out, 0..10
//  rk_valid    out  1    rk_out/rk_idx valid
//  rk_ready    in   1    consumer takes rk_out
//  rk_last     out  1    rk_valid && rk_idx==10
// BEHAVIOUR
//  Reset (async assert, sync deassert at the next clk edge): state=IDLE, rk_out=0, rk_idx=0, rk_valid=0,
//    key_ready=1, Rcon=8'h01.
//  FSM:
//    IDLE: key_ready=1. On key_valid&&key_ready: rk_out<=key_in, rk_idx<=0, rk_valid<=1, Rcon<=01 -> EMIT.
//    EMIT: key_ready=0. rk_out/rk_idx stay stable while rk_valid&&!rk_ready.
//      On handshake with rk_idx<10: rk_out<=next(rk_out), rk_idx<=rk_idx+1, Rcon<=xtime(Rcon); rk_valid stays 1.
//      On handshake with rk_idx==10: rk_valid<=0 -> IDLE.
//  Latency: RK0 valid the cycle after key acceptance. RK(i+1) valid the cycle after the RK(i) handshake.
//    With rk_ready held at 1, RK0..RK10 take 11 consecutive cycles. Best case key-to-key period is 12 cycles.
//  next(w0..w3): t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
//  Rcon sequence 01,02,04,08,10,20,40,80,1B,36. xtime = {r[6:0],1'b0} ^ (r[7] ? 8'h1B : 8'h00).
//  key_valid while in EMIT is ignored: not accepted, no effect. Keys are never queued.
//  rk_ready while rk_valid=0 has no effect.
//  Reset mid-sequence aborts immediately: rk_valid=0 and the FSM returns to IDLE. No partial key survives.
//  rk_idx never exceeds 10. No wrap occurs because the FSM leaves EMIT after index 10.
// CONFIGURATION
//  KEY_SCHED_STORE_EN defined: adds an 11x128 round-key store written on every rk handshake.
//    Extra ports: rd_idx in 4, rd_key out 128 (combinational read), store_full out 1.
//    store_full is set after the RK10 handshake. It is cleared on reset and on the next key acceptance.
//    rd_idx>10 returns 128'h0. Decryption reuses stored keys without re-expansion.
//  KEY_SCHED_STORE_EN undefined: no store, no extra ports. Behaviour is otherwise identical.
// STRUCTURE
//  Shared package aes_pkg: typedefs byte_t/word_t/block_t, RCON_INIT=8'h01, RCON_POLY=8'h1B,
//    NR_AES128=10, the S-box table, and functions xtime() and rot_word().
//  Sub-module aes_sbox_byte (8-bit combinational S-box lookup), instantiated 4x for SubWord. The same lookup is
//    used by byte substitution in the round datapath.
//  FSM, Rcon register, index counter, and optional store live in this top module.
// TESTING
//  1 FIPS-197 A.1: key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> RK0=key,
//    RK1=a0fafe1788542cb123a339392a6c7605, RK10=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_last on RK10 only.
//  2 Backpressure: rk_ready random 30% -> rk_out/rk_idx stable while stalled; same 11 keys as scenario 1.
//  3 Key during EMIT: pulse key_valid with key 000..0 at rk_idx=4 -> ignored, key_ready=0, RK10 unchanged.
//  4 Back-to-back: key2 000102..0f offered on the cycle after the RK10 handshake -> accepted, RK10=13111d7fe3944a17f307a78b4d2b30c5.
//  5 Reset mid-run: rst_n=0 at rk_idx=6 -> rk_valid=0 and key_ready=1 immediately; after release, rerun
//    scenario 1 -> correct.
//  6 KEY_SCHED_STORE_EN: after scenario 1, rd_idx=1 -> a0fafe17..7605, rd_idx=11 -> 0, store_full=1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, constants, S-box table and byte/word helpers.
// Used by the key schedule and by the round datapath's byte substitution.
package aes_pkg;
  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic {S_IDLE, S_EMIT} ks_state_t;

  localparam byte_t RCON_INIT = 8'h01;
  localparam byte_t RCON_POLY = 8'h1B;
  localparam int    NR_AES128 = 10;

  localparam byte_t SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic byte_t xtime(input byte_t r);
    return {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction
endpackage

// File: rtl/aes_sbox_byte.sv
// Combinational AES S-box lookup for one byte.
module aes_sbox_byte
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  assign o_byte = SBOX[i_byte];
endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES-128 key expansion: emits RK0..RK10, one per valid/ready beat.
// Optional round-key store with combinational read port: define KEY_SCHED_STORE_EN.
module key_schedule_seq
  import aes_pkg::*;
#(
  parameter int NR    = NR_AES128,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [KEY_W-1:0] rk_out,
  output logic [3:0]       rk_idx,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             rk_last
`ifdef KEY_SCHED_STORE_EN
  ,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key,
  output logic             store_full
`endif
);
  localparam logic [3:0] LAST_IDX = 4'(NR);

  ks_state_t        r_state;
  logic [KEY_W-1:0] r_rk;
  logic [3:0]       r_idx;
  logic             r_valid;
  logic             r_key_ready;
  byte_t            r_rcon;

  word_t            w_rot, w_sub, w_t;
  word_t            w_n0, w_n1, w_n2, w_n3;
  logic             w_hs, w_accept;

  assign w_hs     = r_valid && rk_ready;
  assign w_accept = (r_state == S_IDLE) && key_valid && r_key_ready;
  assign w_rot    = rot_word(r_rk[31:0]);

  // SubWord: one S-box lane per byte of the rotated last word
  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox_byte u_sbox (
      .i_byte (w_rot[g*8 +: 8]),
      .o_byte (w_sub[g*8 +: 8])
    );
  end

  assign w_t  = w_sub ^ {r_rcon, 24'h0};
  assign w_n0 = r_rk[127:96] ^ w_t;
  assign w_n1 = r_rk[95:64]  ^ w_n0;
  assign w_n2 = r_rk[63:32]  ^ w_n1;
  assign w_n3 = r_rk[31:0]   ^ w_n2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rk        <= '0;
      r_idx       <= '0;
      r_valid     <= 1'b0;
      r_key_ready <= 1'b1;
      r_rcon      <= RCON_INIT;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_rk        <= key_in;
          r_idx       <= '0;
          r_valid     <= 1'b1;
          r_rcon      <= RCON_INIT;
          r_key_ready <= 1'b0;
          r_state     <= S_EMIT;
        end
        S_EMIT: if (w_hs) begin
          if (r_idx == LAST_IDX) begin
            r_valid     <= 1'b0;
            r_key_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_rk   <= {w_n0, w_n1, w_n2, w_n3};
            r_idx  <= r_idx + 4'd1;
            r_rcon <= xtime(r_rcon);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign key_ready = r_key_ready;
  assign rk_out    = r_rk;
  assign rk_idx    = r_idx;
  assign rk_valid  = r_valid;
  assign rk_last   = r_valid && (r_idx == LAST_IDX);

`ifdef KEY_SCHED_STORE_EN
  logic [KEY_W-1:0] r_store [0:NR];
  logic             r_full;

  // Data array needs no reset; r_full says when its contents are a complete schedule
  always_ff @(posedge clk) begin
    if (w_hs) r_store[r_idx] <= r_rk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_full <= 1'b0;
    else if (w_accept)                   r_full <= 1'b0;
    else if (w_hs && r_idx == LAST_IDX)  r_full <= 1'b1;
  end

  assign rd_key     = (rd_idx <= LAST_IDX) ? r_store[rd_idx] : '0;
  assign store_full = r_full;
`endif
endmodule

// File: tb/tb_key_schedule_seq.sv
// Self-checking bench for key_schedule_seq: FIPS-197 vectors, backpressure, corner sequences, random keys.
// Reference model derives the S-box from GF(2^8) inversion plus the affine map.
module tb_key_schedule_seq;
  typedef logic [10:0][127:0] rks_t;
  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] exp;
    int           pct;
  } vec_t;

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SEQ_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic         rk_last;
`ifdef KEY_SCHED_STORE_EN
  logic [3:0]   rd_idx = '0;
  logic [127:0] rd_key;
  logic         store_full;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] m_sb [256];

  key_schedule_seq dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .rk_out(rk_out), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_last(rk_last)
`ifdef KEY_SCHED_STORE_EN
    , .rd_idx(rd_idx), .rd_key(rd_key), .store_full(store_full)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {m_sb[w[31:24]], m_sb[w[23:16]], m_sb[w[15:8]], m_sb[w[7:0]]};
  endfunction

  // Textbook FIPS-197 expansion over a 44-word array
  function automatic rks_t expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    rks_t        r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n < 11; n++) r[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    return r;
  endfunction

  // Called at a negedge with the block idle; returns at the negedge after the RK10 handshake.
  task automatic run_key(input logic [127:0] key, input int pct, input int inj, output rks_t got);
    int  n = 0, cyc = 0;
    bit  stalled = 0, rdy;
    logic [127:0] p_out = '0;
    logic [3:0]   p_idx = '0;
    got = '0;
    while (!key_ready && cyc < 50) begin @(negedge clk); cyc++; end
    chk("key_ready_idle", {127'd0, key_ready}, 128'd1);
    key_in = key; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    cyc = 0;
    while (n < 11 && cyc < 500) begin
      if (!rk_valid) begin
        chk("rk_valid_emit", {127'd0, rk_valid}, 128'd1);
        break;
      end
      if (stalled) begin
        chk("stall_out", rk_out, p_out);
        chk("stall_idx", {124'd0, rk_idx}, {124'd0, p_idx});
      end
      chk("rk_idx", {124'd0, rk_idx}, 128'(n));
      chk("rk_last", {127'd0, rk_last}, {127'd0, (n == 10)});
      if (inj >= 0 && int'(rk_idx) == inj) begin
        key_valid = 1'b1; key_in = '0;
        chk("key_ready_emit", {127'd0, key_ready}, 128'd0);
      end else key_valid = 1'b0;
      rdy = ($urandom_range(99) < pct);
      rk_ready = rdy;
      if (rdy) begin got[n] = rk_out; n++; end
      stalled = !rdy; p_out = rk_out; p_idx = rk_idx;
      @(negedge clk); cyc++;
    end
    if (n < 11) chk("beats", 128'(n), 128'd11);
    rk_ready = 1'b0; key_valid = 1'b0;
    chk("done_valid", {127'd0, rk_valid}, 128'd0);
  endtask

  task automatic chk_all(input string nm, input rks_t got, input rks_t exp);
    for (int i = 0; i < 11; i++) chk(nm, got[i], exp[i]);
  endtask

  initial begin
    vec_t tbl [5];
    rks_t got, exp;
    logic [127:0] rk_key;
    logic [7:0] inv, b;
    int cyc;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      b = inv;
      m_sb[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end

    tbl[0] = '{K_FIPS, 0,  K_FIPS,    100};
    tbl[1] = '{K_FIPS, 1,  FIPS_RK1,  100};
    tbl[2] = '{K_FIPS, 10, FIPS_RK10, 100};
    tbl[3] = '{K_SEQ,  10, SEQ_RK10,  100};
    tbl[4] = '{K_FIPS, 10, FIPS_RK10, 30};

    // reset state
    #12;
    chk("rst_valid", {127'd0, rk_valid}, 128'd0);
    chk("rst_ready", {127'd0, key_ready}, 128'd1);
    chk("rst_out", rk_out, 128'd0);
    chk("rst_idx", {124'd0, rk_idx}, 128'd0);
    chk("rst_last", {127'd0, rk_last}, 128'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // rk_ready while idle does nothing
    rk_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_rdy_valid", {127'd0, rk_valid}, 128'd0);
    chk("idle_rdy_idx", {124'd0, rk_idx}, 128'd0);
    rk_ready = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run_key(tbl[v].key, tbl[v].pct, -1, got);
      chk($sformatf("vec%0d", v), got[tbl[v].idx], tbl[v].exp);
      chk_all($sformatf("vec%0d_model", v), got, expand(tbl[v].key));
    end

`ifdef KEY_SCHED_STORE_EN
    chk("store_full", {127'd0, store_full}, 128'd1);
    rd_idx = 4'd1;  #1 chk("rd_1", rd_key, FIPS_RK1);
    rd_idx = 4'd10; #1 chk("rd_10", rd_key, FIPS_RK10);
    rd_idx = 4'd11; #1 chk("rd_11", rd_key, 128'd0);
`endif

    // key offered during EMIT is ignored
    run_key(K_FIPS, 100, 4, got);
    chk("inj_rk10", got[10], FIPS_RK10);

    // back-to-back: second key offered right after the RK10 handshake
    run_key(K_FIPS, 100, -1, got);
    run_key(K_SEQ, 100, -1, got);
    chk("b2b_rk10", got[10], SEQ_RK10);

    // reset mid-run at rk_idx 6
    key_in = K_FIPS; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
`ifdef KEY_SCHED_STORE_EN
    chk("full_clr", {127'd0, store_full}, 128'd0);
`endif
    rk_ready = 1'b1;
    cyc = 0;
    while (rk_idx != 4'd6 && cyc < 50) begin @(negedge clk); cyc++; end
    chk("reach_idx6", {124'd0, rk_idx}, 128'd6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {127'd0, rk_valid}, 128'd0);
    chk("mid_rst_ready", {127'd0, key_ready}, 128'd1);
    chk("mid_rst_idx", {124'd0, rk_idx}, 128'd0);
    rk_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_key(K_FIPS, 100, -1, got);
    chk("post_rst_rk1", got[1], FIPS_RK1);
    chk("post_rst_rk10", got[10], FIPS_RK10);

    // random keys under random backpressure
    for (int r = 0; r < 6; r++) begin
      rk_key = {$urandom, $urandom, $urandom, $urandom};
      exp = expand(rk_key);
      run_key(rk_key, 30 + 10 * r, -1, got);
      chk_all($sformatf("rand%0d", r), got, exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
